nf_page_reader: RTL
===================

# nf_page_reader

Sequencer directly upstream of the NAND byte-read engine: after the command/address phase of a page read, waits for the flash ready/busy line, then drives the byte engine once per byte, collects each returned byte and packs four bytes into a 32-bit word. Words go out on a valid/ready stream toward the data buffer. Backpressure on the stream stalls further flash reads, so no data is lost.

## Interface
- PAGE_BYTES, 2112: maximum bytes per page read (data + spare).
- LEN_W, 12: width of the length input; must hold PAGE_BYTES.
- TRR, 16'd2: clocks from synchronized R/B high to the first read_en (tRR min 20 ns at 100 MHz).

- clk  in  1  system clock, max 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a page read; ignored unless busy=0.
- len  in  LEN_W  bytes to read, sampled on accepted start; values above PAGE_BYTES are clamped to PAGE_BYTES.
- nf_rb_n  in  1  flash ready/busy_n, asynchronous; 0 = busy.
- read_en  out  1  one-cycle pulse to the byte engine requesting one byte.
- rd_ack  in  1  one-cycle completion strobe from the byte engine.
- rd_data  in  8  byte from the byte engine, valid in the cycle rd_ack=1.
- word_data  out  32  packed word.
- word_valid  out  1  word_data valid; held until accepted.
- word_ready  in  1  downstream accept.
- word_last  out  1  qualifies the final word of the page.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, WAIT_RB, ISSUE, WAIT_ACK, PUSH, DONE.
- IDLE: start with busy=0 latches remain=min(len,PAGE_BYTES), clears byte lane index and word register, goes to WAIT_RB. If len=0, go straight to DONE and emit no words.
- WAIT_RB: wait until the synchronized rb=1, then count TRR clocks (the count restarts if rb drops), then go to ISSUE.
- ISSUE: assert read_en for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK: on rd_ack, write rd_data into word lane idx (bits 8*idx+7:8*idx, first byte in bits 7:0), decrement remain, increment idx mod 4. If idx wraps to 0 or remain reaches 0, go to PUSH; otherwise go to ISSUE.
- PUSH: word_valid=1 and word_last=(remain==0). On word_ready, clear the word register. If remain==0, go to DONE; otherwise go to ISSUE.
- DONE: pulse done for one cycle, then go to IDLE.
- Partial last word: unfilled upper lanes are 0.
- No new read_en is issued until the previous rd_ack arrives and any full word has been accepted.
- rd_ack outside WAIT_ACK is ignored.
- start while busy is ignored.

## Timing
- Reset values: read_en=0, word_valid=0, word_last=0, word_data=0, busy=0, done=0; state=IDLE; synchronizer flops=0 (reads as busy).
- nf_rb_n goes through a 2-FF synchronizer, adding 2 clocks of latency.
- First read_en: no earlier than 2+TRR clocks after nf_rb_n rises, and never while synchronized rb=0.
- read_en to next read_en: rd_ack latency plus 1 clock (ISSUE follows the ack cycle).
- Word path: word_valid rises the cycle after the 4th rd_ack; with word_ready=1 it is held for 1 cycle.
- done rises the clock after the last word handshake.
- rst asserted mid-operation: all outputs go to reset values immediately. An outstanding byte engine cycle completes on its own, and its ack is ignored.

## Structure
- Shared package nf_pkg holds the state enum, TRR and the tRR/tREA timing constants shared with the byte engine and write engine, plus the PAGE_BYTES default.
- Sub-module nf_sync2: a generic 2-FF synchronizer for nf_rb_n, reusable by the program/erase sequencers.
- The datapath (word register, lane index, remain counter) stays inline.

## Test plan
- len=8, rb high, byte model returns 0x01..0x08 with 3-clock ack latency, ready=1 → words 0x04030201 then 0x08070605 (last=1), 8 read_en pulses, one done pulse.
- len=5 → words 0x04030201 and 0x00000005 with last=1 on the second.
- nf_rb_n low for 50 clocks after start → no read_en until 2+TRR clocks after rb rises; rb glitch low during TRR count restarts the count.
- word_ready held low 20 clocks on the first word of len=8 → word_valid and data stable, no read_en during the stall, 5th read_en only after the accept.
- len=0 → done 1 clock after DONE entry, no read_en, no word_valid. len=4000 → exactly 2112 read_en pulses and 528 words.
- rst pulsed during WAIT_ACK of byte 3, then a fresh start with len=4 → outputs at reset values, stale ack ignored, the new page packs correctly.

Source files
------------

// File: rtl/nf_pkg.sv
// Shared NAND flash constants and types for the read, program and erase sequencers.
package nf_pkg;

    localparam int          NF_PAGE_BYTES   = 2112;
    localparam int          NF_LEN_W        = 12;
    localparam int          NF_CLK_PERIOD_NS = 10;
    localparam int          NF_T_RR_NS      = 20;
    localparam int          NF_T_REA_NS     = 20;
    // tRR expressed in clocks at the nominal 100 MHz system clock.
    localparam logic [15:0] NF_TRR          = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RB  = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_PUSH     = 3'd4,
        ST_DONE     = 3'd5
    } nf_state_e;

endpackage

// File: rtl/nf_sync2.sv
// Generic two-flop synchronizer for slow asynchronous flash status lines.
module nf_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nf_page_reader.sv
// Page read sequencer: waits on R/B#, drives the byte engine one byte at a time
// and packs bytes little-endian into 32-bit words on a valid/ready stream.
module nf_page_reader
    import nf_pkg::*;
#(
    parameter int          PAGE_BYTES = NF_PAGE_BYTES,
    parameter int          LEN_W      = NF_LEN_W,
    parameter logic [15:0] TRR        = NF_TRR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             nf_rb_n,
    output logic             read_en,
    input  logic             rd_ack,
    input  logic [7:0]       rd_data,
    output logic [31:0]      word_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             word_last,
    output logic             busy,
    output logic             done,
    output nf_state_e        state_dbg
);

    // Stream contract: word_valid, word_data and word_last stay stable until a
    // cycle with word_valid && word_ready; that cycle is the transfer.

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAGE_BYTES);

    nf_state_e        state, state_nxt;
    logic             rb_s;
    logic [LEN_W-1:0] remain;
    logic [LEN_W-1:0] len_clamped;
    logic [1:0]       idx;
    logic [31:0]      word_reg;
    logic [15:0]      trr_cnt;

    nf_sync2 #(.RESET_VAL(1'b0)) u_rb_sync (
        .clk (clk),
        .rst (rst),
        .d   (nf_rb_n),
        .q   (rb_s)
    );

    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len_clamped == '0) ? ST_DONE : ST_WAIT_RB;
                end
            end
            ST_WAIT_RB: begin
                if (rb_s && (trr_cnt == TRR - 16'd1)) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (rd_ack) begin
                    // Flush on a full word or on the final byte of the page.
                    if ((idx == 2'd3) || (remain == LEN_W'(1))) begin
                        state_nxt = ST_PUSH;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_PUSH: begin
                if (word_ready) begin
                    state_nxt = (remain == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        read_en    = (state == ST_ISSUE);
        word_valid = (state == ST_PUSH);
        word_last  = (state == ST_PUSH) && (remain == '0);
        word_data  = word_reg;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        state_dbg  = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain   <= '0;
            idx      <= '0;
            word_reg <= '0;
            trr_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remain   <= len_clamped;
                        idx      <= '0;
                        word_reg <= '0;
                        trr_cnt  <= '0;
                    end
                end
                ST_WAIT_RB: begin
                    // Any busy indication restarts the tRR wait from zero.
                    if (!rb_s) begin
                        trr_cnt <= '0;
                    end else begin
                        trr_cnt <= trr_cnt + 16'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (rd_ack) begin
                        word_reg[{idx, 3'b000} +: 8] <= rd_data;
                        remain                       <= remain - LEN_W'(1);
                        idx                          <= idx + 2'd1;
                    end
                end
                ST_PUSH: begin
                    if (word_ready) begin
                        word_reg <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
